// File: rtl/alu_mc_pkg.sv
// rtl/alu_mc_pkg.sv - shared opcode, state and flag definitions for alu_mc
// MUL is always enumerated; whether it executes depends on ALU_MC_MUL_EN in alu_mc.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    NOP    = 4'd0,
    CLB    = 4'd1,
    ADD    = 4'd2,
    SUB    = 4'd3,
    ORR    = 4'd4,
    AND    = 4'd5,
    XOR    = 4'd6,
    LSH    = 4'd7,
    RXOR_7 = 4'd8,
    RXOR_8 = 4'd9,
    MUL    = 4'd10
  } op_mne;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_mc_state_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic neg;
    logic err;
  } alu_flags_t;

  localparam alu_flags_t FLAGS_RST = '{zero: 1'b1, carry: 1'b0, neg: 1'b0, err: 1'b0};

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier, one multiplier bit per cycle
// Only instantiated when ALU_MC_MUL_EN is defined; done/product are valid in the final step cycle.
module alu_mul_iter #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic           busy;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   a_q;
  logic [2*W-1:0] p_q;
  logic [W:0]     psum;
  logic [2*W-1:0] p_next;

  // Upper half accumulates the multiplicand; the multiplier drains out of the lower half.
  always_comb begin
    psum   = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, a_q} : '0);
    p_next = {psum, p_q[W-1:1]};
  end

  assign done    = busy && (cnt == CNT_LAST);
  assign product = p_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      a_q  <= '0;
      p_q  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      a_q  <= a;
      p_q  <= {{W{1'b0}}, b};
    end else if (busy) begin
      p_q <= p_next;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered valid/ready ALU with flags and optional iterative MUL
// Define ALU_MC_MUL_EN to build the multiplier; otherwise MUL reports Err like any illegal opcode.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  op_mne        ALU_OP,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Out,
  output logic [W-1:0] OutHi,
  output logic         Zero,
  output logic         Carry,
  output logic         Neg,
  output logic         Err
);

  localparam int SHW = $clog2(W);
  localparam logic [W-1:0] W_LIM = W'(W);

  alu_mc_state_t  state_q, state_d;
  logic           accept;
  logic           is_mul;
  logic           mul_done;
  logic [W-1:0]   res;
  logic           carry_c;
  logic           err_c;
  logic [W:0]     sum;
  logic [2*W-1:0] shl;
  alu_flags_t     flags_d, flags_q;
  logic [W-1:0]   out_q;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);

  always_comb begin
    res     = '0;
    carry_c = 1'b0;
    err_c   = 1'b0;
    sum     = '0;
    shl     = '0;
    case (ALU_OP)
      NOP: res = A;
      CLB: begin
        res        = A;
        res[W-1]   = 1'b0;
      end
      ADD: begin
        sum     = {1'b0, A} + {1'b0, B};
        res     = sum[W-1:0];
        carry_c = sum[W];
      end
      SUB: begin
        // Bit W of the widened difference is the borrow (A < B).
        sum     = {1'b0, A} - {1'b0, B};
        res     = sum[W-1:0];
        carry_c = sum[W];
      end
      ORR: res = A | B;
      AND: res = A & B;
      XOR: res = A ^ B;
      LSH: begin
        if (A >= W_LIM) begin
          res     = '0;
          carry_c = |B;
        end else begin
          shl     = {{W{1'b0}}, B} << A[SHW-1:0];
          res     = shl[W-1:0];
          carry_c = |shl[2*W-1:W];
        end
      end
      RXOR_7: res[0] = ^A[W-2:0];
      RXOR_8: res[0] = ^A;
`ifdef ALU_MC_MUL_EN
      MUL: res = '0;
`endif
      default: err_c = 1'b1;
    endcase
    flags_d = '{zero: (res == '0), carry: carry_c, neg: res[W-1], err: err_c};
  end

`ifdef ALU_MC_MUL_EN
  logic [2*W-1:0] mul_prod;
  logic [W-1:0]   hi_q;

  assign is_mul = (ALU_OP == MUL);

  alu_mul_iter #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (accept && is_mul),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (mul_prod)
  );
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_mul ? BUSY : DONE;
      BUSY: if (mul_done) state_d = DONE;
      DONE: if (out_ready) state_d = accept ? (is_mul ? BUSY : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result and flags load together so they always describe the presented result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      flags_q <= FLAGS_RST;
    end else if (accept && !is_mul) begin
      out_q   <= res;
      flags_q <= flags_d;
`ifdef ALU_MC_MUL_EN
    end else if ((state_q == BUSY) && mul_done) begin
      out_q   <= mul_prod[W-1:0];
      flags_q <= '{zero: (mul_prod[W-1:0] == '0), carry: 1'b0,
                   neg: mul_prod[W-1], err: 1'b0};
`endif
    end
  end

`ifdef ALU_MC_MUL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              hi_q <= '0;
    else if (accept && !is_mul)             hi_q <= '0;
    else if ((state_q == BUSY) && mul_done) hi_q <= mul_prod[2*W-1:W];
  end
  assign OutHi = hi_q;
`else
  assign OutHi = '0;
`endif

  assign Out   = out_q;
  assign Zero  = flags_q.zero;
  assign Carry = flags_q.carry;
  assign Neg   = flags_q.neg;
  assign Err   = flags_q.err;

endmodule
